// File: rtl/cache_defs.sv
// Shared cache-subsystem definitions: default geometry of the data memory
// path and the write-buffer drain state encoding.
package cache_defs;
    localparam int WB_DEPTH    = 4;
    localparam int WORD_ADDR_W = 10;
    localparam int WORD_DATA_W = 32;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_WRITE = 1'b1
    } wb_state_e;
endpackage

// File: rtl/wb_fifo_store.sv
// Write-buffer storage: circular FIFO of address/data entries with in-place
// coalescing of pushes and youngest-first associative read forwarding.
module wb_fifo_store
    import cache_defs::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WORD_ADDR_W,
    parameter int DATA_W = WORD_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              head_locked,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] next_addr,
    output logic [DATA_W-1:0] next_data,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data
);
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  head, tail, next_ptr, fwd_idx, coal_idx;
    logic              coal, alloc;

    assign full     = (count == CNT_W'(DEPTH));
    assign next_ptr = head + PTR_W'(1);

    // The locked head is already on the memory bus, so it must never absorb a push.
    always_comb begin
        coal     = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && addr_q[i] == push_addr &&
                !(head_locked && PTR_W'(i) == head)) begin
                coal     = push;
                coal_idx = PTR_W'(i);
            end
        end
    end

    assign alloc = push && !coal && (!full || pop);

    // Entries loaded onto the bus on the same edge as a coalesce take the new data.
    assign head_addr = addr_q[head];
    assign head_data = (coal && coal_idx == head) ? push_data : data_q[head];
    assign next_addr = addr_q[next_ptr];
    assign next_data = (coal && coal_idx == next_ptr) ? push_data : data_q[next_ptr];

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if (valid[fwd_idx] && addr_q[fwd_idx] == rd_addr) begin
                rd_hit  = 1'b1;
                rd_data = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= next_ptr;
            end
            if (alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (coal)
            data_q[coal_idx] <= push_data;
        if (alloc && !rst) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
    end
endmodule

// File: rtl/cache_write_buffer.sv
// Write-through buffer between the D-cache controller and main data memory:
// buffers writes in one cycle and drains them through a ready handshake.
module cache_write_buffer
    import cache_defs::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WORD_ADDR_W,
    parameter int DATA_W = WORD_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_push,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_full,
    output logic              wb_empty,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_state_e         state;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] head_addr, next_addr;
    logic [DATA_W-1:0] head_data, next_data;

    assign pop      = mem_write && mem_ready;
    assign wb_empty = (count == '0);

    wb_fifo_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_store (
        .clk         (clk),
        .rst         (rst),
        .push        (wb_push),
        .push_addr   (wb_addr),
        .push_data   (wb_data),
        .pop         (pop),
        .head_locked (mem_write),
        .rd_addr     (rd_addr),
        .full        (wb_full),
        .count       (count),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .next_addr   (next_addr),
        .next_data   (next_data),
        .rd_hit      (rd_hit),
        .rd_data     (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WB_IDLE;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (count != '0) begin
                        state     <= WB_WRITE;
                        mem_write <= 1'b1;
                        mem_addr  <= head_addr;
                        mem_wdata <= head_data;
                    end
                end
                WB_WRITE: begin
                    // Back-to-back drain: the entry behind the popped head goes out next.
                    if (mem_ready) begin
                        if (count > CNT_W'(1)) begin
                            mem_addr  <= next_addr;
                            mem_wdata <= next_data;
                        end else begin
                            state     <= WB_IDLE;
                            mem_write <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= WB_IDLE;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/cache_write_buffer.md
Name: cache_write_buffer

Overview:
Write-through write buffer between the data-cache controller and the word-addressed main data memory. Accepts cache write requests in one cycle and drains them to main memory through a ready handshake. This hides memory write latency from the processor on write hits and write misses. Read misses query the buffer so memory refills never return stale data.

Parameters:
DEPTH, 4, number of buffered write entries (power of two, >=2)
ADDR_W, 10, word-address width (matches WordAddress)
DATA_W, 32, data word width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
wb_push  in  1  cache controller requests buffering of one write
wb_addr  in  ADDR_W  word address of pushed write
wb_data  in  DATA_W  data of pushed write
wb_full  out  1  no free entry; a push will not be accepted unless coalesced or concurrent pop
wb_empty  out  1  no valid entries and no write in flight
rd_addr  in  ADDR_W  read-miss address probed for forwarding (combinational lookup)
rd_hit  out  1  rd_addr matches a valid entry
rd_data  out  DATA_W  data of youngest matching entry, 0 when rd_hit=0
mem_write  out  1  write request to main memory (registered)
mem_addr  out  ADDR_W  address of entry being drained (registered)
mem_wdata  out  DATA_W  data of entry being drained (registered)
mem_ready  in  1  main memory accepts the current write on this edge

Behaviour:
- Reset: at a rising edge with rst=1, all entries are invalidated and the drain FSM goes to IDLE. After that edge: wb_full=0, wb_empty=1, rd_hit=0, rd_data=0, mem_write=0, mem_addr=0, mem_wdata=0. rst overrides a concurrent push or mem_ready, and any in-flight write is abandoned.
- Storage: circular FIFO with head/tail pointers and count 0..DEPTH. Pointers wrap modulo DEPTH.
- Push accepted at an edge when wb_push=1 and any of the following holds:
  - count<DEPTH;
  - the push coalesces;
  - a pop occurs on the same edge.
- Push ignored when full with no pop and no coalesce. The cache controller must stall while wb_full=1.
- Coalescing: if wb_addr matches a valid entry other than the locked head (the head is locked while mem_write=1), that entry's data is overwritten in place. Count and order are unchanged. At most one unlocked entry can match.
- Drain FSM has two states: IDLE and WRITE.
  - IDLE and count>0: the next edge enters WRITE and loads the head into mem_addr/mem_wdata, with mem_write=1.
  - WRITE: outputs are held stable until an edge samples mem_ready=1. That edge pops the head.
  - After the pop, if entries remain, the FSM stays in WRITE and loads the new head on the same edge (back-to-back drain, no bubble). Otherwise it returns to IDLE with mem_write=0.
- mem_ready is ignored when mem_write=0.
- Latency: a push into an empty buffer at edge N gives mem_write=1 after edge N+1. The entry is freed at the first edge with mem_ready=1.
- wb_full = (count==DEPTH). wb_empty = (count==0), where the head stays counted until popped.
- Forwarding: combinational compare of rd_addr against all valid entries, including the locked head. On multiple matches, the youngest (closest to tail) wins. A push on the same cycle is not visible until after its edge.
- Simultaneous push and pop at full: accepted; count stays DEPTH.
- Simultaneous push to the locked head's address: a new entry is allocated (no coalesce), so memory sees both writes in order.

Decomposition:
- Shared header/package cache_defs: ADDR_W, DATA_W, DEPTH defaults and drain-state encodings (WB_IDLE, WB_WRITE), also used by the cache controller and Data_Mem_Top.
- One natural sub-module, wb_fifo_store: entry arrays, valid bits, pointers, count, coalesce write port and associative match logic.
- The top level holds the drain FSM and the memory-side registers.

Test Plan:
- Reset mid-drain: push 0x001/32'hffffaaaa, hold mem_ready=0 for 3 cycles, assert rst one cycle -> after that edge mem_write=0, wb_empty=1, rd_hit=0.
- Single write: push 0x001/32'hffffaaaa into empty buffer, mem_ready=1 two cycles later -> mem_write=1 with mem_addr=0x001, mem_wdata=32'hffffaaaa one cycle after push; wb_empty=1 the cycle after the mem_ready edge.
- Fill and stall: mem_ready=0, push 0x000..0x003 with data 32'h10..32'h13, then push 0x004 -> wb_full=1, the 5th push is dropped. Release mem_ready=1 -> memory sees 0x000..0x003 in order, back-to-back, one per cycle.
- Coalesce: with head 0x000 locked, push 0x002/32'haaaa0000 then 0x002/32'hccccbbbb -> count increases by one only; memory later receives 0x002/32'hccccbbbb once.
- Forwarding: entries 0x001/32'hffffaaaa (head, locked) and a new push 0x001/32'hccccbbbb, rd_addr=0x001 -> rd_hit=1, rd_data=32'hccccbbbb; rd_addr=0x005 -> rd_hit=0, rd_data=0.
- Push+pop at full: DEPTH entries, mem_write=1, mem_ready=1 and wb_push=1 on the same edge -> count stays 4, wb_full stays 1, the new entry is drained last.
